writeback_stage: RTL

- Final pipeline stage and the write side of the register-file port that the decode stage reads.
- Registers memory-stage results and selects the write-back value. Loads are lane-extracted and sign/zero-extended.
- Drives rd data, address and write enable into the decode-stage register file, and counts retired instructions.

---
 rtl/writeback_stage.sv | 120 ++++++++++++
 1 files changed

// File: rtl/writeback_stage.sv
// Final pipeline stage: registers memory-stage results, extracts and extends load
// data, selects the register-file write value and counts retired instructions.
module writeback_stage #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_stall_wb,
    input  logic                  i_flush_wb,
    input  logic                  i_valid,
    input  logic [2:0]            i_result_src,
    input  logic                  i_reg_we,
    input  logic [REG_ADDR_W-1:0] i_rd_addr,
    input  logic [2:0]            i_func3,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    input  logic [DATA_WIDTH-1:0] i_mem_read_data,
    input  logic [ADDR_WIDTH-1:0] i_pc_plus4,
    input  logic [ADDR_WIDTH-1:0] i_pc_target,
    input  logic [DATA_WIDTH-1:0] i_imm_ext,
    output logic [DATA_WIDTH-1:0] o_rd_write_data,
    output logic [REG_ADDR_W-1:0] o_rd_addr,
    output logic                  o_reg_we,
    output logic [63:0]           o_retired_count
);

    logic                  valid_q;
    logic                  reg_we_q;
    logic [2:0]            result_src_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [2:0]            func3_q;
    logic [DATA_WIDTH-1:0] alu_result_q;
    logic [DATA_WIDTH-1:0] mem_data_q;
    logic [ADDR_WIDTH-1:0] pc_plus4_q;
    logic [ADDR_WIDTH-1:0] pc_target_q;
    logic [DATA_WIDTH-1:0] imm_ext_q;
    logic [63:0]           retired_q;

    always_ff @(posedge i_clk) begin
        if (!i_arst) begin
            valid_q      <= 1'b0;
            reg_we_q     <= 1'b0;
            result_src_q <= '0;
            rd_q         <= '0;
            func3_q      <= '0;
            alu_result_q <= '0;
            mem_data_q   <= '0;
            pc_plus4_q   <= '0;
            pc_target_q  <= '0;
            imm_ext_q    <= '0;
            retired_q    <= '0;
        end else begin
            // Retire when the occupant leaves the stage; a stalled one is counted on release.
            if (valid_q && !i_stall_wb)
                retired_q <= retired_q + 64'd1;

            if (i_flush_wb) begin
                valid_q  <= 1'b0;
                reg_we_q <= 1'b0;
            end else if (!i_stall_wb) begin
                valid_q      <= i_valid;
                reg_we_q     <= i_reg_we;
                result_src_q <= i_result_src;
                rd_q         <= i_rd_addr;
                func3_q      <= i_func3;
                alu_result_q <= i_alu_result;
                mem_data_q   <= i_mem_read_data;
                pc_plus4_q   <= i_pc_plus4;
                pc_target_q  <= i_pc_target;
                imm_ext_q    <= i_imm_ext;
            end
        end
    end

    // Lane extraction; low offset bits below the access size are dropped.
    logic [2:0]            off;
    logic [7:0]            byte_v;
    logic [15:0]           half_v;
    logic [31:0]           word_v;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] result;

    assign off    = alu_result_q[2:0];
    assign byte_v = 8'(mem_data_q >> {off, 3'b000});
    assign half_v = 16'(mem_data_q >> {off[2:1], 4'b0000});
    assign word_v = 32'(mem_data_q >> {off[2], 5'b00000});

    always_comb begin
        load_data = '0;
        case (func3_q)
            3'b000:  load_data = {{(DATA_WIDTH-8){byte_v[7]}}, byte_v};
            3'b001:  load_data = {{(DATA_WIDTH-16){half_v[15]}}, half_v};
            3'b010:  load_data = {{(DATA_WIDTH-32){word_v[31]}}, word_v};
            3'b011:  load_data = mem_data_q;
            3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, byte_v};
            3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, half_v};
            3'b110:  load_data = {{(DATA_WIDTH-32){1'b0}}, word_v};
            default: load_data = '0;
        endcase
    end

    always_comb begin
        result = '0;
        case (result_src_q)
            3'b000:  result = alu_result_q;
            3'b001:  result = load_data;
            3'b010:  result = DATA_WIDTH'(pc_plus4_q);
            3'b011:  result = imm_ext_q;
            3'b100:  result = DATA_WIDTH'(pc_target_q);
            default: result = '0;
        endcase
    end

    assign o_rd_write_data = result;
    assign o_rd_addr       = rd_q;
    assign o_reg_we        = reg_we_q && valid_q && (rd_q != '0);
    assign o_retired_count = retired_q;

endmodule
